// File: rtl/addsub_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// addsub_arbiter_pkg
// Shared definitions for the add/sub arbiter slice.
//   state_t : FSM state encoding (IDLE / EXEC / DONE)
//   ID_R0/1 : requester identifiers carried with each operation into res_id
// -----------------------------------------------------------------------------
package addsub_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic ID_R0 = 1'b0;
    localparam logic ID_R1 = 1'b1;

endpackage

// File: rtl/addsub_arbiter_if.sv
// -----------------------------------------------------------------------------
// addsub_arbiter_if
// Bundles the two requester handshakes, the result handshake and the status
// outputs of addsub_arbiter.
//   master : client side (drives valid/operands/res_ready, sees ready/results)
//   slave  : arbiter side (the mirror image)
// Parameters: W (operand width), CNT_W (op counter width).
// -----------------------------------------------------------------------------
interface addsub_arbiter_if #(
    parameter int W     = 4,
    parameter int CNT_W = 16
);
    logic             r0_valid;
    logic             r0_ready;
    logic [W-1:0]     r0_a;
    logic [W-1:0]     r0_b;
    logic             r0_m;

    logic             r1_valid;
    logic             r1_ready;
    logic [W-1:0]     r1_a;
    logic [W-1:0]     r1_b;
    logic             r1_m;

    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_s;
    logic             res_c;
    logic             res_v;
    logic             res_id;

    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport master (
        output r0_valid, r0_a, r0_b, r0_m,
        output r1_valid, r1_a, r1_b, r1_m,
        output res_ready,
        input  r0_ready, r1_ready,
        input  res_valid, res_s, res_c, res_v, res_id,
        input  busy, op_count
    );

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_m,
        input  r1_valid, r1_a, r1_b, r1_m,
        input  res_ready,
        output r0_ready, r1_ready,
        output res_valid, res_s, res_c, res_v, res_id,
        output busy, op_count
    );
endinterface

// File: rtl/addsub_cla.sv
// -----------------------------------------------------------------------------
// addsub_cla
// W-bit carry-lookahead adder/subtractor, purely combinational.
//   a, b : operands        m : 0 = a+b, 1 = a-b
//   s    : result          c : carry out of bit W-1 (subtract: 1 = no borrow)
//   v    : signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module addsub_cla #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         m,
    output logic [W-1:0] s,
    output logic         c,
    output logic         v
);
    logic [W-1:0] bx;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   cy;

    assign bx = b ^ {W{m}};
    assign g  = a & bx;
    assign p  = a ^ bx;

    // Lookahead recurrence c[i+1] = g[i] | p[i]&c[i], flattened by synthesis.
    always_comb begin
        cy    = '0;
        cy[0] = m;
        for (int i = 0; i < W; i++) begin
            cy[i+1] = g[i] | (p[i] & cy[i]);
        end
    end

    assign s = p ^ cy[W-1:0];
    assign c = cy[W];
    assign v = cy[W] ^ cy[W-1];
endmodule

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset (prio -> 0)
//   en       : arbitration allowed this cycle
//   req[1:0] : requests            gnt[1:0] : one-hot grant (combinational)
// A lone request always wins. On contention requester `prio` wins and prio
// moves to the other side; prio is otherwise left alone.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (&req) gnt = prio ? 2'b10 : 2'b01;
            else      gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                prio <= 1'b0;
        else if (en && (&req))  prio <= ~gnt[1];
    end
endmodule

// File: rtl/addsub_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_arbiter
// Shares one addsub_cla between two requesters; one operation in flight.
//   clk, rst : clock, synchronous active-high reset
//   bus      : addsub_arbiter_if.slave - requester handshakes r0_*/r1_*,
//              result handshake res_*, busy and op_count status
//
//   state   | meaning
//   IDLE    | waiting for a request; grant and latch operands on accept
//   EXEC    | datapath works on latched operands; results captured at edge
//   DONE    | results presented, held until res_ready
// -----------------------------------------------------------------------------
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    addsub_arbiter_if.slave   bus
);
    state_t           state, state_nxt;
    logic [1:0]       gnt;
    logic             arb_en;
    logic             r0_ready, r1_ready;

    logic [W-1:0]     op_a, op_b;
    logic             op_m, op_id;
    logic [W-1:0]     dp_s;
    logic             dp_c, dp_v;

    logic [W-1:0]     res_s;
    logic             res_c, res_v, res_id, res_valid;
    logic [CNT_W-1:0] op_count;

    // Blocking the arbiter during reset keeps both readies low while rst is high.
    assign arb_en = (state == ST_IDLE) && !rst;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({bus.r1_valid, bus.r0_valid}),
        .gnt (gnt)
    );

    addsub_cla #(.W(W)) u_cla (
        .a (op_a),
        .b (op_b),
        .m (op_m),
        .s (dp_s),
        .c (dp_c),
        .v (dp_v)
    );

    always_comb begin
        state_nxt = state;
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                r0_ready = gnt[0];
                r1_ready = gnt[1];
                if (|gnt) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: if (bus.res_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            op_m      <= 1'b0;
            op_id     <= ID_R0;
            res_s     <= '0;
            res_c     <= 1'b0;
            res_v     <= 1'b0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (gnt[1]) begin
                        op_a  <= bus.r1_a;
                        op_b  <= bus.r1_b;
                        op_m  <= bus.r1_m;
                        op_id <= ID_R1;
                    end else if (gnt[0]) begin
                        op_a  <= bus.r0_a;
                        op_b  <= bus.r0_b;
                        op_m  <= bus.r0_m;
                        op_id <= ID_R0;
                    end
                end
                ST_EXEC: begin
                    res_s     <= dp_s;
                    res_c     <= dp_c;
                    res_v     <= dp_v;
                    res_id    <= op_id;
                    res_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.r0_ready  = r0_ready;
    assign bus.r1_ready  = r1_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_s     = res_s;
    assign bus.res_c     = res_c;
    assign bus.res_v     = res_v;
    assign bus.res_id    = res_id;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.op_count  = op_count;
endmodule
